// File: rtl/dpr_load_arb.sv
// Block-load arbiter: streams loader bytes into a RAM write port through a
// one-entry holding buffer, with CPU writes always taking priority.
module dpr_load_arb #(
   parameter int KB = 16,
   localparam int AW = $clog2(KB * 1024)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   len,
   input  logic          ld_valid,
   input  logic [7:0]    ld_data,
   output logic          ld_ready,
   input  logic          cw,
   input  logic [AW-1:0] ca,
   input  logic [7:0]    cd,
   output logic [AW-1:0] a2,
   output logic [7:0]    d2,
   output logic          w2,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   localparam logic [AW:0]   REM_ONE  = 1;
   localparam logic [AW-1:0] ADDR_ONE = 1;

   state_t        state, state_n;
   logic [AW-1:0] addr;
   logic [AW:0]   rem, rem_n;
   logic          full, full_n;
   logic [7:0]    hold;
   logic          accept, start_ok, ld_ready_n;

   assign accept   = ld_valid && ld_ready;
   assign start_ok = start && (state == IDLE || state == DONE);

   always_comb begin
      state_n = state;
      rem_n   = rem;
      full_n  = full;
      if (accept)
         full_n = 1'b1;
      else if (full && !cw)
         full_n = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               rem_n   = len;
               state_n = (len == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (accept)
               rem_n = rem - REM_ONE;
            if (rem_n == '0)
               state_n = DRAIN;
         end
         DRAIN: begin
            // the buffer is seen empty only after its write has issued
            if (!full)
               state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
      ld_ready_n = (state_n == LOAD) && (rem_n != '0) && !full_n;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         addr     <= '0;
         rem      <= '0;
         full     <= 1'b0;
         hold     <= '0;
         ld_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         w2       <= 1'b0;
         a2       <= '0;
         d2       <= '0;
      end else begin
         state    <= state_n;
         rem      <= rem_n;
         full     <= full_n;
         ld_ready <= ld_ready_n;
         busy     <= (state_n == LOAD) || (state_n == DRAIN);
         done     <= (state_n == DONE);
         if (accept)
            hold <= ld_data;
         if (start_ok)
            addr <= base;
         else if (full && !cw)
            addr <= addr + ADDR_ONE;
         if (cw) begin
            w2 <= 1'b1;
            a2 <= ca;
            d2 <= cd;
         end else if (full) begin
            w2 <= 1'b1;
            a2 <= addr;
            d2 <= hold;
         end else begin
            w2 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dpr_load_arb.sv
// Directed self-checking bench for dpr_load_arb (KB=16, AW=14).
module tb_dpr_load_arb;

   localparam int AW = 14;

   logic          clock = 1'b0;
   logic          reset, start, ld_valid, ld_ready, cw, w2, busy, done;
   logic [AW-1:0] base, ca, a2;
   logic [AW:0]   len;
   logic [7:0]    ld_data, cd, d2;

   int checks = 0;
   int errors = 0;

   logic [7:0]      mem [0:(2**AW)-1];
   logic [AW+7:0]   wlog [$];

   dpr_load_arb #(.KB(16)) dut (
      .clock(clock), .reset(reset), .start(start), .base(base), .len(len),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .cw(cw), .ca(ca), .cd(cd), .a2(a2), .d2(d2), .w2(w2),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (w2) begin
         mem[a2] = d2;
         wlog.push_back({a2, d2});
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic feed(input logic [7:0] bytes [8], input int cnt, output int n);
      int   idx;
      logic acc;
      idx = 0;
      n = 0;
      ld_valid = (cnt > 0);
      ld_data = bytes[0];
      while (!done && n < 100) begin
         acc = ld_valid && ld_ready;
         tick;
         n++;
         if (acc) begin
            idx++;
            if (idx >= cnt) ld_valid = 1'b0;
            else ld_data = bytes[idx];
         end
      end
      ld_valid = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL feed_timeout got done=%b want 1 after %0d cycles", done, n);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b1; base = 14'h0123; len = 15'd5;
      cw = 1'b1; ca = 14'h0456; cd = 8'h5A; ld_valid = 1'b1; ld_data = 8'h77;
      tick;
      tick;
      checks++;
      if ({w2, ld_ready, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {w2, ld_ready, busy, done});
      end
      checks++;
      if (a2 !== '0 || d2 !== '0) begin
         errors++;
         $display("FAIL reset_port got a2=%h d2=%h want 0 0", a2, d2);
      end
      reset = 1'b0; start = 1'b0; cw = 1'b0; ld_valid = 1'b0;
      tick;
      checks++;
      if ({busy, done, ld_ready, w2} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_after_reset got %b want 0000", {busy, done, ld_ready, w2});
      end
      wlog.delete();
   endtask

   task automatic test_basic_load;
      logic [7:0]    b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0};
      logic [AW+7:0] e;
      int n;
      wlog.delete();
      start = 1'b1; base = 14'h0100; len = 15'd4;
      tick;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_load_entry got busy=%b ld_ready=%b want 1 1", busy, ld_ready);
      end
      feed(b, 4, n);
      checks++;
      if (n != 9) begin
         errors++;
         $display("FAIL basic_latency got %0d want 9", n);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL basic_end got busy=%b done=%b want 0 1", busy, done);
      end
      checks++;
      if (wlog.size() != 4) begin
         errors++;
         $display("FAIL basic_count got %0d want 4", wlog.size());
      end
      for (int i = 0; i < 4 && i < wlog.size(); i++) begin
         e = {14'h0100 + 14'(i), b[i]};
         checks++;
         if (wlog[i] !== e) begin
            errors++;
            $display("FAIL basic_write%0d got %h want %h", i, wlog[i], e);
         end
      end
   endtask

   task automatic test_cpu_priority;
      logic [7:0] cdv [3] = '{8'hAA, 8'hBB, 8'hCC};
      wlog.delete();
      start = 1'b1; base = 14'h0300; len = 15'd2;
      tick;
      start = 1'b0; ld_valid = 1'b1; ld_data = 8'h55;
      tick;
      ld_valid = 1'b0; cw = 1'b1; ca = 14'h2000;
      for (int i = 0; i < 3; i++) begin
         cd = cdv[i];
         tick;
         checks++;
         if (w2 !== 1'b1 || a2 !== 14'h2000 || d2 !== cdv[i]) begin
            errors++;
            $display("FAIL cpu_write%0d got w2=%b a2=%h d2=%h want 1 2000 %h", i, w2, a2, d2, cdv[i]);
         end
         checks++;
         if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL cpu_stall_ready%0d got %b want 0", i, ld_ready);
         end
      end
      cw = 1'b0;
      tick;
      checks++;
      if (w2 !== 1'b1 || a2 !== 14'h0300 || d2 !== 8'h55) begin
         errors++;
         $display("FAIL cpu_pending got w2=%b a2=%h d2=%h want 1 0300 55", w2, a2, d2);
      end
      ld_valid = 1'b1; ld_data = 8'h66;
      tick;
      ld_valid = 1'b0;
      tick;
      checks++;
      if (w2 !== 1'b1 || a2 !== 14'h0301 || d2 !== 8'h66) begin
         errors++;
         $display("FAIL cpu_second got w2=%b a2=%h d2=%h want 1 0301 66", w2, a2, d2);
      end
      tick;
      checks++;
      if (done !== 1'b1 || wlog.size() != 5) begin
         errors++;
         $display("FAIL cpu_end got done=%b writes=%0d want 1 5", done, wlog.size());
      end
   endtask

   task automatic test_wrap;
      logic [7:0]    b [8] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 0, 0, 0, 0};
      logic [AW-1:0] ea [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
      logic [AW+7:0] e;
      int n;
      wlog.delete();
      start = 1'b1; base = 14'h3FFE; len = 15'd4;
      tick;
      start = 1'b0;
      feed(b, 4, n);
      checks++;
      if (wlog.size() != 4) begin
         errors++;
         $display("FAIL wrap_count got %0d want 4", wlog.size());
      end
      for (int i = 0; i < 4 && i < wlog.size(); i++) begin
         e = {ea[i], b[i]};
         checks++;
         if (wlog[i] !== e) begin
            errors++;
            $display("FAIL wrap_write%0d got %h want %h", i, wlog[i], e);
         end
      end
   endtask

   task automatic test_len_zero_and_ignored_start;
      logic [7:0] b [8] = '{8'hC1, 8'hC2, 0, 0, 0, 0, 0, 0};
      int n;
      wlog.delete();
      start = 1'b1; base = 14'h0123; len = 15'd0;
      tick;
      start = 1'b0;
      checks++;
      if ({done, busy, ld_ready, w2} !== 4'b1000) begin
         errors++;
         $display("FAIL len0 got done,busy,ready,w2=%b want 1000", {done, busy, ld_ready, w2});
      end
      tick;
      checks++;
      if (done !== 1'b1 || w2 !== 1'b0 || ld_ready !== 1'b0 || wlog.size() != 0) begin
         errors++;
         $display("FAIL len0_hold got done=%b w2=%b ready=%b writes=%0d want 1 0 0 0",
                  done, w2, ld_ready, wlog.size());
      end
      start = 1'b1; base = 14'h0500; len = 15'd2;
      tick;
      base = 14'h0600; len = 15'd0;
      tick;
      start = 1'b0;
      checks++;
      if ({busy, done, ld_ready} !== 3'b101) begin
         errors++;
         $display("FAIL ignored_start got busy,done,ready=%b want 101", {busy, done, ld_ready});
      end
      feed(b, 2, n);
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL ignored_latency got %0d want 5", n);
      end
      checks++;
      if (wlog.size() != 2 || wlog[0] !== {14'h0500, 8'hC1} || wlog[1] !== {14'h0501, 8'hC2}) begin
         errors++;
         $display("FAIL ignored_writes got n=%0d first=%h want 2 0500c1/0501c2",
                  wlog.size(), (wlog.size() > 0) ? wlog[0] : '0);
      end
   endtask

   task automatic test_reset_mid_load;
      logic [7:0] b [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      int   idx, writes;
      logic acc;
      wlog.delete();
      mem[14'h0702] = 8'h00;
      start = 1'b1; base = 14'h0700; len = 15'd8;
      tick;
      start = 1'b0; ld_valid = 1'b1; ld_data = b[0];
      idx = 0; writes = 0;
      for (int c = 0; c < 20 && writes < 2; c++) begin
         acc = ld_valid && ld_ready;
         tick;
         if (w2) writes++;
         if (acc) begin
            idx++;
            ld_data = b[idx];
         end
      end
      reset = 1'b1; start = 1'b1; cw = 1'b1; ca = 14'h0702; cd = 8'hEE;
      tick;
      checks++;
      if ({busy, done, ld_ready, w2} !== 4'b0000 || a2 !== '0 || d2 !== '0) begin
         errors++;
         $display("FAIL abort got busy,done,ready,w2=%b a2=%h d2=%h want 0000 0 0",
                  {busy, done, ld_ready, w2}, a2, d2);
      end
      reset = 1'b0; start = 1'b0; cw = 1'b0; ld_valid = 1'b0;
      tick;
      tick;
      checks++;
      if (wlog.size() != 2 || mem[14'h0700] !== 8'h01 || mem[14'h0701] !== 8'h02 || mem[14'h0702] !== 8'h00) begin
         errors++;
         $display("FAIL abort_ram got writes=%0d m700=%h m701=%h m702=%h want 2 01 02 00",
                  wlog.size(), mem[14'h0700], mem[14'h0701], mem[14'h0702]);
      end
      checks++;
      if ({busy, done, ld_ready, w2} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_idle got %b want 0000", {busy, done, ld_ready, w2});
      end
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = 8'h00;
      reset = 1'b1; start = 1'b0; base = '0; len = '0;
      ld_valid = 1'b0; ld_data = '0; cw = 1'b0; ca = '0; cd = '0;
      test_reset;
      test_basic_load;
      test_cpu_priority;
      test_wrap;
      test_len_zero_and_ignored_start;
      test_reset_mid_load;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
